i2c_bus_decoder: RTL
====================

Name: i2c_bus_decoder

Overview:
Synthesizable receive-side decoder that consumes the two-wire I2C bus (the sda/scl pair of the team's I2C interface) and converts it into a stream of bus events: START, repeated START, STOP, and complete bytes with their ACK bit. It is a passive tap: it samples the lines and never drives them. It sits directly downstream of the bus interface and feeds protocol checkers, scoreboards, or an RTL target/monitor core through a valid/ready event port.

Parameters:
SYNC_STAGES, 2, flops in each input synchronizer chain (minimum 2).
FILTER_LEN, 3, consecutive clk cycles a synchronized line must hold a new level before the filtered level changes (minimum 1).

Ports:
clk  input  1  system clock; all logic on its rising edge.
rst_n  input  1  asynchronous, active-low reset.
sda_i  input  1  raw bus SDA sample, asynchronous to clk.
scl_i  input  1  raw bus SCL sample, asynchronous to clk.
evt_valid  output  1  event held in the output register.
evt_ready  input  1  consumer accepts the event when evt_valid && evt_ready.
evt_type  output  2  0=START, 1=RSTART, 2=STOP, 3=BYTE.
evt_data  output  8  received byte, MSB first on the wire; 0 for non-BYTE events.
evt_ack  output  1  BYTE only: 1 when the 9th-bit SDA was low (ACK).
evt_first  output  1  BYTE only: 1 for the first byte after START/RSTART (address byte).
bus_busy  output  1  1 from START detection until STOP detection.
overflow  output  1  sticky flag: an event was dropped.
clr_overflow  input  1  synchronous clear of overflow; takes priority over a same-cycle set.

Behaviour:
- Reset: synchronizer flops and filtered levels = 1 (idle bus). evt_valid, evt_type, evt_data, evt_ack, evt_first, bus_busy, overflow, bit counter = 0. State = IDLE.
- Input path: each line passes through SYNC_STAGES flops, then the filter. The filter has a per-line counter that increments while the synchronized level differs from the filtered level and resets to 0 when they match. When the counter reaches FILTER_LEN, the filtered level toggles.
- Pin-to-filtered latency is SYNC_STAGES+FILTER_LEN cycles. Pulses shorter than FILTER_LEN cycles are rejected.
- Edge detection uses previous and current filtered values (sda_f, scl_f).
  - START: sda_f falls while scl_f is 1 in both the previous and current cycle.
  - STOP: sda_f rises under the same scl condition.
  - Bit sample: scl_f rising edge; the captured value is the current sda_f.
  - If sda_f and scl_f change in the same cycle, this is neither START nor STOP. If SCL rose, a bit is sampled.
- States: IDLE, BITS. The bit counter is 4 bits wide and runs 0..8.
  - IDLE + START: emit START, set bus_busy, go to BITS, clear counter, set first_pending.
  - BITS + START: emit RSTART, clear counter, set first_pending, discard any partial byte.
  - BITS + bit sample: counters 0..7 shift the bit into the data register. Counter 8 captures ACK = !sda_f, emits BYTE with evt_first=first_pending, clears first_pending, and resets the counter to 0.
  - Any state + STOP: emit STOP, clear bus_busy, go to IDLE, discard any partial byte. A STOP seen in IDLE is still emitted.
  - IDLE + bit sample: ignored (no START seen, e.g. after a mid-transfer reset).
- Event output: a single register. The event appears with evt_valid=1 on the cycle after the detecting filtered edge. It is held stable until accepted. evt_valid drops the cycle after acceptance unless a new event loads in that same cycle.
- Overflow: if a new event is detected while evt_valid=1 and evt_ready=0, the new event is dropped, the held event is unchanged, and overflow=1. If acceptance and a new event occur in the same cycle, the new event loads without overflow.
- Non-BYTE events drive evt_data, evt_ack, evt_first as 0.
- Reset asserted mid-transfer: all state returns to reset values immediately. The held event is lost.

Test Plan:
- Write 0xA0 (ACK), 0x5A (NACK), then STOP, evt_ready=1 → events START; BYTE data=0xA0 ack=1 first=1; BYTE data=0x5A ack=0 first=0; STOP. bus_busy is 1 between START and STOP.
- START, 0xA0 ACK, RSTART, 0xA1 ACK, STOP → START, BYTE(0xA0, first=1), RSTART, BYTE(0xA1, first=1), STOP.
- FILTER_LEN=3: 2-cycle SCL high glitch mid-byte → no bit sampled; next byte still decodes correctly. A 3-cycle pulse → sampled.
- evt_ready=0 during START + 0xA0 → START held, BYTE dropped, overflow=1. clr_overflow clears it. Same-cycle accept-and-new-event → no overflow.
- START, 3 data bits, STOP → START then STOP only, no BYTE, FSM in IDLE. The next transaction decodes normally.
- rst_n low after 4 bits of a byte, released, bits continue without START → no events, bus_busy=0. The next START is decoded as START, not RSTART.

Source files
------------

// File: rtl/i2c_bus_decoder.sv
// Passive I2C receive-side decoder: turns the sda/scl pair into START,
// repeated START, STOP and BYTE events on a valid/ready port.
module i2c_bus_decoder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sda_i,
  input  logic       scl_i,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [1:0] evt_type,
  output logic [7:0] evt_data,
  output logic       evt_ack,
  output logic       evt_first,
  output logic       bus_busy,
  output logic       overflow,
  input  logic       clr_overflow
);

  // Counter only needs to reach FILTER_LEN-1; the next qualifying cycle toggles.
  localparam int unsigned CNT_W  = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);
  localparam int unsigned BIT_W  = 4;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    EVT_START  = 2'd0,
    EVT_RSTART = 2'd1,
    EVT_STOP   = 2'd2,
    EVT_BYTE   = 2'd3
  } evt_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BITS = 1'b1
  } state_e;

  // Index 0 carries SDA, index 1 carries SCL through the input path.
  logic [1:0]                  line_raw;
  logic [1:0][SYNC_STAGES-1:0] sync_q, sync_d;
  logic [1:0][CNT_W-1:0]       flt_cnt_q, flt_cnt_d;
  logic [1:0]                  line_f_q, line_f_d;
  logic [1:0]                  line_p_q;

  logic sda_f, scl_f, sda_p, scl_p;
  logic start_c, stop_c, bit_c;

  state_e            state_q, state_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              first_q, first_d;
  logic              busy_q, busy_d;

  logic              evt_valid_q, evt_valid_d;
  evt_e              evt_type_q, evt_type_d;
  logic [DATA_W-1:0] evt_data_q, evt_data_d;
  logic              evt_ack_q, evt_ack_d;
  logic              evt_first_q, evt_first_d;
  logic              ovf_q, ovf_d;

  logic              new_evt;
  evt_e              new_type;
  logic [DATA_W-1:0] new_data;
  logic              new_ack;
  logic              new_first;

  assign line_raw = {scl_i, sda_i};

  // Synchronizer shift and glitch filter: level flips after FILTER_LEN stable cycles.
  always_comb begin
    sync_d    = sync_q;
    flt_cnt_d = flt_cnt_q;
    line_f_d  = line_f_q;
    for (int i = 0; i < 2; i++) begin
      sync_d[i]    = {sync_q[i][SYNC_STAGES-2:0], line_raw[i]};
      flt_cnt_d[i] = '0;
      if (sync_q[i][SYNC_STAGES-1] != line_f_q[i]) begin
        if (flt_cnt_q[i] == CNT_W'(FILTER_LEN - 1)) begin
          line_f_d[i] = ~line_f_q[i];
        end else begin
          flt_cnt_d[i] = flt_cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Input path registers; idle bus level is high on both lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '1;
      flt_cnt_q <= '0;
      line_f_q  <= '1;
      line_p_q  <= '1;
    end else begin
      sync_q    <= sync_d;
      flt_cnt_q <= flt_cnt_d;
      line_f_q  <= line_f_d;
      line_p_q  <= line_f_q;
    end
  end

  assign sda_f = line_f_q[0];
  assign scl_f = line_f_q[1];
  assign sda_p = line_p_q[0];
  assign scl_p = line_p_q[1];

  // Bus conditions from previous/current filtered levels; SCL must be high in both.
  assign start_c = scl_p & scl_f & sda_p & ~sda_f;
  assign stop_c  = scl_p & scl_f & ~sda_p & sda_f;
  assign bit_c   = ~scl_p & scl_f;

  // Protocol tracking, event generation and the single-entry event register.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    data_d      = data_q;
    first_d     = first_q;
    busy_d      = busy_q;
    new_evt     = 1'b0;
    new_type    = EVT_START;
    new_data    = '0;
    new_ack     = 1'b0;
    new_first   = 1'b0;
    evt_valid_d = evt_valid_q;
    evt_type_d  = evt_type_q;
    evt_data_d  = evt_data_q;
    evt_ack_d   = evt_ack_q;
    evt_first_d = evt_first_q;
    ovf_d       = ovf_q;

    if (stop_c) begin
      new_evt   = 1'b1;
      new_type  = EVT_STOP;
      busy_d    = 1'b0;
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      data_d    = '0;
    end else if (start_c) begin
      new_evt   = 1'b1;
      new_type  = (state_q == ST_BITS) ? EVT_RSTART : EVT_START;
      busy_d    = 1'b1;
      state_d   = ST_BITS;
      bit_cnt_d = '0;
      data_d    = '0;
      first_d   = 1'b1;
    end else if (bit_c && (state_q == ST_BITS)) begin
      if (bit_cnt_q == BIT_W'(8)) begin
        new_evt   = 1'b1;
        new_type  = EVT_BYTE;
        new_data  = data_q;
        new_ack   = ~sda_f;
        new_first = first_q;
        first_d   = 1'b0;
        bit_cnt_d = '0;
      end else begin
        data_d    = {data_q[DATA_W-2:0], sda_f};
        bit_cnt_d = bit_cnt_q + BIT_W'(1);
      end
    end

    // A held, unaccepted event wins; a newcomer is dropped and flagged.
    if (new_evt && (!evt_valid_q || evt_ready)) begin
      evt_valid_d = 1'b1;
      evt_type_d  = new_type;
      evt_data_d  = new_data;
      evt_ack_d   = new_ack;
      evt_first_d = new_first;
    end else if (evt_valid_q && evt_ready) begin
      evt_valid_d = 1'b0;
    end

    if (new_evt && evt_valid_q && !evt_ready) begin
      ovf_d = 1'b1;
    end
    if (clr_overflow) begin
      ovf_d = 1'b0;
    end
  end

  // Protocol and event state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      data_q      <= '0;
      first_q     <= 1'b0;
      busy_q      <= 1'b0;
      evt_valid_q <= 1'b0;
      evt_type_q  <= EVT_START;
      evt_data_q  <= '0;
      evt_ack_q   <= 1'b0;
      evt_first_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      data_q      <= data_d;
      first_q     <= first_d;
      busy_q      <= busy_d;
      evt_valid_q <= evt_valid_d;
      evt_type_q  <= evt_type_d;
      evt_data_q  <= evt_data_d;
      evt_ack_q   <= evt_ack_d;
      evt_first_q <= evt_first_d;
      ovf_q       <= ovf_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_type  = evt_type_q;
  assign evt_data  = evt_data_q;
  assign evt_ack   = evt_ack_q;
  assign evt_first = evt_first_q;
  assign bus_busy  = busy_q;
  assign overflow  = ovf_q;

endmodule
